cordic_vectoring_core: RTL
==========================

# cordic_vectoring_core

Iterative CORDIC engine in vectoring mode. It rotates an input vector (x, y) onto the positive x-axis and produces its magnitude and its angle atan2(y, x). The angle is a 16-bit binary angle, 2^16 LSB per turn, so 0x2000 = 45° and 0x8000 = 180°. The core consumes the arctangent ROM one entry per iteration, driving the ROM address from its iteration counter, and sits between the sample front end and the polar-output consumers.

## Interface
Parameters:
- WORD_LENGTH, 16, width of x_in, y_in and angle_out.
- ADDRESS_LENGTH, 4, ROM address width.
- ITERATIONS, 16, iterations per conversion; legal range 1..2^ADDRESS_LENGTH.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a conversion; sampled only in IDLE.
- x_in  in  WORD_LENGTH  signed x, captured when start is accepted.
- y_in  in  WORD_LENGTH  signed y, captured when start is accepted.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse; results are valid from this cycle on.
- mag_out  out  WORD_LENGTH+2  unsigned magnitude; held until the next accepted start.
- angle_out  out  WORD_LENGTH  binary angle, wraps mod 2^16; held until the next accepted start.

## Operation
- FSM states: IDLE → ROTATE → (SCALE, only when the macro is defined) → DONE → IDLE.
- IDLE: on start = 1, capture the inputs sign-extended to WORD_LENGTH+2 bits and apply pre-rotation:
  - x_in < 0: x0 = −x, y0 = −y, z0 = 0x8000.
  - Otherwise: x0 = x, y0 = y, z0 = 0.
  - Set iter = 0 and go to ROTATE.
- ROTATE: ROM address = iter. Each cycle, with a = ROM data:
  - y ≥ 0: x += y>>>iter, y −= x>>>iter, z += a.
  - y < 0: x −= y>>>iter, y += x>>>iter, z −= a.
  - Both updates use the pre-update x and y. Shifts are arithmetic (truncate toward −∞).
  - z is WORD_LENGTH bits and wraps modulo 2^16.
  - After iter = ITERATIONS−1, go to the next state.
- DONE: load mag_out = x and angle_out = z, pulse done, return to IDLE.
- start while busy, including in DONE, is ignored; it is neither queued nor allowed to corrupt the computation.
- Internal x/y width is WORD_LENGTH+2. This covers −(−32768), and the worst-case CORDIC gain growth on (−32768, −32768) ≈ 76314, with no overflow.
- Input (0, 0): mag 0, angle 0.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, busy 0, done 0, mag_out 0, angle_out 0, internal registers 0.
- Start accepted at edge E0. ROTATE occupies edges E1..E_ITERATIONS. done is high for exactly the cycle after edge E_(ITERATIONS+1), and busy falls with it.
- Latency:
  - Macro off: start-accept edge to done = ITERATIONS+1 cycles.
  - Macro on: ITERATIONS+2 cycles.
- Throughput: one conversion per ITERATIONS+2 (macro off) or ITERATIONS+3 (macro on) cycles; the earliest next accept is the cycle after done.
- Reset mid-conversion aborts immediately to the reset values; no done is issued.

## Configuration
- CORDIC_GAIN_COMP_EN:
  - Defined: a SCALE state follows ROTATE and computes mag = (x × 19898) >>> 15, i.e. 1/K ≈ 0.60725, with a shift-add or single multiply. mag_out is then the true magnitude.
  - Undefined: no SCALE state, and mag_out = raw x, which carries gain K ≈ 1.64676.

## Structure
- Package cordic_pkg holds:
  - the FSM state encoding;
  - GUARD_BITS = 2;
  - ANGLE_PI = 0x8000;
  - K_INV_Q15 = 19898.
- One sub-module: the existing arctangent ROM, 4-bit address and 16-bit word, instantiated once with its address driven by iter.
- Everything else stays in cordic_vectoring_core.

## Test plan
- (16384, 0) → angle 0x0000 ±8 LSB; mag 26981 ±4 with the macro off, 16384 ±4 with it on.
- (0, 16384) → angle 0x4000 ±8; (16384, 16384) → angle 0x2000 ±8, mag 38157 ±6 with the macro off.
- (−16384, 0) → angle 0x8000 ±8; (−32768, −32768) → angle 0xA000 ±8, mag 76314 ±8 with the macro off, no overflow.
- Pulse start again 3 cycles after accept → ignored; the first result is unchanged and exactly one done arrives at the specified latency.
- Assert rst_n low at iteration 5 → busy, done and the outputs go to 0 immediately; the next start completes normally.
- Back-to-back starts issued the cycle after each done over 100 random vectors → each angle within ±8 LSB of the atan2 model, and each mag within ±0.1% of the model.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC vectoring core: FSM encoding, guard bits and angle/gain constants.
package cordic_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ROTATE = 2'd1;
  localparam logic [1:0] ST_SCALE  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int GUARD_BITS = 2;

  // Binary angle for 180 degrees (2^16 LSB per turn).
  localparam logic [15:0] ANGLE_PI = 16'h8000;

  // 1/K in Q15, used by the optional gain compensation step.
  localparam int K_INV_Q15 = 19898;

endpackage

// File: rtl/cordic_atan_rom.sv
// Arctangent ROM: atan(2^-addr) as a 16-bit binary angle (2^16 LSB per turn), rounded to nearest.
module cordic_atan_rom (
  input  logic [3:0]  addr,
  output logic [15:0] data
);

  always_comb begin
    data = 16'd0;
    case (addr)
      4'd0:  data = 16'd8192;
      4'd1:  data = 16'd4836;
      4'd2:  data = 16'd2555;
      4'd3:  data = 16'd1297;
      4'd4:  data = 16'd651;
      4'd5:  data = 16'd326;
      4'd6:  data = 16'd163;
      4'd7:  data = 16'd81;
      4'd8:  data = 16'd41;
      4'd9:  data = 16'd20;
      4'd10: data = 16'd10;
      4'd11: data = 16'd5;
      4'd12: data = 16'd3;
      4'd13: data = 16'd1;
      4'd14: data = 16'd1;
      default: data = 16'd0;
    endcase
  end

endmodule

// File: rtl/cordic_vectoring_core.sv
// Iterative CORDIC vectoring engine: magnitude and atan2 angle of (x_in, y_in).
// Optional gain compensation state enabled by defining CORDIC_GAIN_COMP_EN.
module cordic_vectoring_core
  import cordic_pkg::*;
#(
  parameter int WORD_LENGTH    = 16,
  parameter int ADDRESS_LENGTH = 4,
  parameter int ITERATIONS     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [WORD_LENGTH-1:0]   x_in,
  input  logic [WORD_LENGTH-1:0]   y_in,
  output logic                     busy,
  output logic                     done,
  output logic [WORD_LENGTH+1:0]   mag_out,
  output logic [WORD_LENGTH-1:0]   angle_out
);

  localparam int XW = WORD_LENGTH + GUARD_BITS;
  localparam logic [ADDRESS_LENGTH-1:0] LAST_ITER = ADDRESS_LENGTH'(ITERATIONS - 1);

  logic [1:0]                state_q, state_d;
  logic signed [XW-1:0]      x_q, x_d, y_q, y_d;
  logic signed [XW-1:0]      x_ext, y_ext, x_sh, y_sh;
  logic [WORD_LENGTH-1:0]    z_q, z_d;
  logic [ADDRESS_LENGTH-1:0] iter_q, iter_d;
  logic                      zero_q, zero_d;
  logic                      done_q, done_d;
  logic [XW-1:0]             mag_q, mag_d;
  logic [WORD_LENGTH-1:0]    angle_q, angle_d;
  logic [15:0]               atan_w;
  logic [WORD_LENGTH-1:0]    atan_a;

  cordic_atan_rom u_rom (
    .addr (iter_q),
    .data (atan_w)
  );

  assign atan_a = WORD_LENGTH'(atan_w);
  assign x_ext  = {{GUARD_BITS{x_in[WORD_LENGTH-1]}}, x_in};
  assign y_ext  = {{GUARD_BITS{y_in[WORD_LENGTH-1]}}, y_in};
  assign x_sh   = x_q >>> iter_q;
  assign y_sh   = y_q >>> iter_q;

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [16:0] K_S = 17'(K_INV_Q15);
  logic signed [XW+16:0] prod;
  assign prod = x_q * K_S;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    iter_d  = iter_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    mag_d   = mag_q;
    angle_d = angle_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Pre-rotate left-half-plane inputs by 180 degrees so the iterations converge.
          if (x_in[WORD_LENGTH-1]) begin
            x_d = -x_ext;
            y_d = -y_ext;
            z_d = WORD_LENGTH'(ANGLE_PI);
          end else begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = '0;
          end
          iter_d  = '0;
          zero_d  = (x_in == '0) && (y_in == '0);
          state_d = ST_ROTATE;
        end
      end
      ST_ROTATE: begin
        if (!y_q[XW-1]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_a;
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_a;
        end
        iter_d = iter_q + 1'b1;
        if (iter_q == LAST_ITER) begin
          iter_d = '0;
`ifdef CORDIC_GAIN_COMP_EN
          state_d = ST_SCALE;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      ST_SCALE: begin
        x_d     = prod[XW+14:15];
        state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        // A zero vector never converges in y, so its angle is forced to 0.
        mag_d   = x_q;
        angle_d = zero_q ? '0 : z_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      iter_q  <= '0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      mag_q   <= '0;
      angle_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      iter_q  <= iter_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      mag_q   <= mag_d;
      angle_q <= angle_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign mag_out   = mag_q;
  assign angle_out = angle_q;

endmodule
